// File: rtl/mult_acc_amplitude_alpha_seq.sv
// Accumulates alpha-rotated complex amplitudes over a group of beats and presents
// the wrapped sum, beat count and illegal-code flag with a valid/ready handshake.
module mult_acc_amplitude_alpha_seq #(
    parameter int complex_bit = 24,
    parameter int cnt_bit     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_alpha,
    input  logic [2*complex_bit-1:0]   in_amplitude,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*complex_bit-1:0]   out_amplitude,
    output logic [cnt_bit-1:0]         out_count,
    output logic                       out_err
);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [cnt_bit-1:0] CNT_ONE = cnt_bit'(1);

    // Multiply by a 2-bit alpha component without a multiplier; illegal code acts as 0.
    function automatic logic signed [complex_bit-1:0] alpha_sel(
        input logic [1:0]                    code,
        input logic signed [complex_bit-1:0] x
    );
        case (code)
            2'b01:   return x;
            2'b11:   return -x;
            default: return '0;
        endcase
    endfunction

    state_t                        state_q, state_d;
    logic signed [complex_bit-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [cnt_bit-1:0]            cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic signed [complex_bit-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic [cnt_bit-1:0]            out_cnt_q, out_cnt_d;
    logic                          out_err_q, out_err_d;

    logic signed [complex_bit-1:0] x_re, x_im, p_re, p_im, sum_re, sum_im;
    logic                          illegal, accept;

    assign x_re    = in_amplitude[2*complex_bit-1:complex_bit];
    assign x_im    = in_amplitude[complex_bit-1:0];
    assign p_re    = alpha_sel(in_alpha[3:2], x_re) - alpha_sel(in_alpha[1:0], x_im);
    assign p_im    = alpha_sel(in_alpha[3:2], x_im) + alpha_sel(in_alpha[1:0], x_re);
    assign sum_re  = acc_re_q + p_re;
    assign sum_im  = acc_im_q + p_im;
    assign illegal = (in_alpha[3:2] == 2'b10) || (in_alpha[1:0] == 2'b10);
    assign accept  = in_valid && in_ready;

    assign in_ready      = (state_q == ACC);
    assign out_valid     = (state_q == HOLD);
    assign out_amplitude = {out_re_q, out_im_q};
    assign out_count     = out_cnt_q;
    assign out_err       = out_err_q;

    always_comb begin
        state_d   = state_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_cnt_d = out_cnt_q;
        out_err_d = out_err_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (in_last) begin
                        out_re_d  = sum_re;
                        out_im_d  = sum_im;
                        out_cnt_d = cnt_q + CNT_ONE;
                        out_err_d = err_q | illegal;
                        acc_re_d  = '0;
                        acc_im_d  = '0;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        acc_re_d  = sum_re;
                        acc_im_d  = sum_im;
                        cnt_d     = cnt_q + CNT_ONE;
                        err_d     = err_q | illegal;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_cnt_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            out_cnt_q <= out_cnt_d;
            out_err_q <= out_err_d;
        end
    end

endmodule

// File: doc/mult_acc_amplitude_alpha_seq.md
MULT_ACC_AMPLITUDE_ALPHA_SEQ -- requirements
Module: mult_acc_amplitude_alpha_seq

Interface
REQ-001 Parameter: complex_bit, default 24, width of each real/imag amplitude component (two's complement).
REQ-002 Parameter: cnt_bit, default 8, width of the group beat counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept an input beat.
REQ-007 in_alpha  input  4  phase code {r[3:2], i[1:0]}, each a 2-bit signed component.
REQ-008 in_amplitude  input  2*complex_bit  {real, imag}, real in the upper half.
REQ-009 in_last  input  1  marks the final beat of a group.
REQ-010 out_valid  output  1  group result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_amplitude  output  2*complex_bit  {real, imag} group sum.
REQ-013 out_count  output  cnt_bit  number of beats in the group.
REQ-014 out_err  output  1  group contained at least one illegal alpha component.

Function
REQ-015 An input beat is accepted when in_valid and in_ready are both high on a rising edge.
REQ-016 Alpha component decode: 2'b00 -> 0, 2'b01 -> +1, 2'b11 -> -1, 2'b10 -> illegal, treated as 0.
REQ-017 Product per beat: P_r = ar*xr - ai*xi and P_i = ar*xi + ai*xr, where (ar, ai) is the decoded alpha and (xr, xi) is the amplitude; no multipliers, select/negate/add only.
REQ-018 All sums wrap modulo 2^complex_bit with no saturation; negation of the most-negative value wraps to itself.
REQ-019 FSM states: ACC (accumulating, in_ready=1) and HOLD (result presented, in_ready=0).
REQ-020 ACC, beat accepted with in_last=0: acc <= acc + P, cnt <= cnt + 1, err <= err | illegal; remain in ACC.
REQ-021 ACC, beat accepted with in_last=1: out_amplitude <= acc + P, out_count <= cnt + 1, out_err <= err | illegal; clear acc, cnt and err; go to HOLD.
REQ-022 Latency: out_valid rises on the first edge after the last beat is accepted.
REQ-023 HOLD: out_valid=1; outputs stay stable until out_ready=1, then go to ACC on the next edge.
REQ-024 in_ready = ~out_valid, so a new group's first beat is accepted no earlier than the edge after the result handshake.
REQ-025 A single-beat group (in_last on the first beat) yields out_count=1 and out_amplitude=P.
REQ-026 Counter wraps modulo 2^cnt_bit; no overflow flag.
REQ-027 In ACC with in_valid=0, the accumulator, counter and error state hold.
REQ-028 Input-side signals are don't-care while in_ready=0.

Reset
REQ-029 While rst_n=0: state=ACC, acc=0, cnt=0, err=0, out_valid=0, out_amplitude=0, out_count=0, out_err=0; in_ready=1 after release.
REQ-030 Reset asserted mid-group or in HOLD discards the partial sum and the pending result immediately, with no output handshake.

Verification
REQ-031 Groups of two beats: alpha=4'b0100 (+1) with amp (5,3), then alpha=4'b0001 (+j) with amp (2,7). The first product is (5,3); the second is +j*(2+7j) = (-7,2). Required result: out_amplitude=(-2,5), out_count=2, out_err=0, out_valid one cycle after the last beat.
REQ-032 Single beat: alpha=4'b1111 (-1-j) with amp (1,0). Required result: (-1,-1), out_count=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles. Required: out_valid and outputs stable for all 5 cycles, in_ready=0 throughout, and a new group is accepted on the edge after the out_ready handshake.
REQ-034 Illegal code: alpha=4'b1001 with amp (4,4). The real component 2'b10 is illegal and treated as 0, leaving 0+j; product = j*(4+4j) = (-4,4). Required: out_amplitude=(-4,4), out_err=1; the next clean group returns out_err=0.
REQ-035 Wrap: two beats of alpha=+1 with amp (2^23-1, 0) at complex_bit=24. Required: out_amplitude real = -2 (wrapped), imag = 0.
REQ-036 Reset mid-group: assert rst_n=0 after 3 beats, then send one group of amp (1,1) with alpha=+1. Required: out_amplitude=(1,1), out_count=1.
